pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Detects load-use hazards (IF/ID sources vs ID/EX load dest),
//  freezes the pipe while data memory is busy, and flushes IF/ID + ID/EX on a taken branch resolved in EX.
//  Drives per-stage write enables and bubble/flush controls; sits beside the pipeline registers in the CPU top.
// PARAMETERS
//  REG_W            4    register-address width
//  LOAD_USE_STALLS  1    bubble cycles per load-use hazard (1..3)
//  MEM_TIMEOUT      15   MEM_WAIT cycles before memTimeout is raised
//  CNT_W            16   width of statistics counters (PIPE_STATS_EN only)
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      synchronous reset, active-low
//  memReadIDEX   in   1      instruction in ID/EX is a load
//  r2IDEX        in   REG_W  load destination register in ID/EX
//  r1IFID        in   REG_W  source reg 1 of instruction in IF/ID
//  r2IFID        in   REG_W  source reg 2 of instruction in IF/ID
//  usesR2IFID    in   1      IF/ID instruction actually reads r2
//  branchTaken   in   1      EX resolved a taken branch this cycle
//  memReq        in   1      MEM stage issuing a data access
//  memAck        in   1      data memory completes the access this cycle
//  pcWrEn        out  1      PC update enable
//  ifidWrEn      out  1      IF/ID register write enable
//  idexBubble    out  1      load NOP into ID/EX instead of decoded instr
//  ifidFlush     out  1      clear IF/ID to NOP
//  idexFlush     out  1      clear ID/EX to NOP
//  exmemWrEn     out  1      EX/MEM register write enable
//  memwbBubble   out  1      load NOP into MEM/WB
//  ctrlState     out  2      current FSM state (RUN=0, LOAD_STALL=1, MEM_WAIT=2)
//  memTimeout    out  1      sticky: MEM_WAIT exceeded MEM_TIMEOUT cycles
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=RUN, stallCnt=0, waitCnt=0, retState=RUN, memTimeout=0. Outputs are combinational
//   from state+inputs; defaults pcWrEn=ifidWrEn=exmemWrEn=1, all bubble/flush=0.
//  loadUse = memReadIDEX & (r2IDEX==r1IFID | (usesR2IFID & r2IDEX==r2IFID)); r0 not exempt.
//  Priority each cycle: memory freeze > branch flush > load-use stall.
//  RUN: memReq&!memAck -> freeze (pcWrEn=ifidWrEn=exmemWrEn=0, memwbBubble=1), retState=RUN, ->MEM_WAIT.
//   else branchTaken -> ifidFlush=idexFlush=1, pcWrEn=1, stay RUN (load-use ignored).
//   else loadUse -> pcWrEn=ifidWrEn=0, idexBubble=1 same cycle; if LOAD_USE_STALLS>1 stallCnt=LOAD_USE_STALLS-1, ->LOAD_STALL.
//  LOAD_STALL: pcWrEn=ifidWrEn=0, idexBubble=1; stallCnt-- ; at stallCnt==1 ->RUN. branchTaken ignored here.
//   memReq&!memAck -> freeze, retState=LOAD_STALL, stallCnt held, ->MEM_WAIT.
//  MEM_WAIT: full freeze; waitCnt++ (saturating). memAck -> outputs as state retState with no new hazard
//   evaluation, waitCnt=0, ->retState. waitCnt==MEM_TIMEOUT -> memTimeout=1 (sticky until reset); stay MEM_WAIT.
//  memReq&memAck same cycle: zero-wait access, no freeze.
//  Reset mid-stall/mid-wait: abandons sequence, returns to RUN defaults next cycle.
// CONFIGURATION
//  PIPE_STATS_EN defined: extra outputs loadStallCnt, memWaitCnt, flushCnt (CNT_W each), saturating, cleared by reset;
//   increment once per stall cycle, freeze cycle, branch flush respectively.
//  PIPE_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared header pipe_ctrl_defs.vh: state encodings (RUN/LOAD_STALL/MEM_WAIT), NOP-select constants.
//  One sub-module: load_use_compare (pure combinational loadUse equation, REG_W parameterised).
//  FSM, stall/wait counters and optional stats live in pipeline_stall_ctrl.
// TESTING
//  memReadIDEX=1,r2IDEX=3,r1IFID=3 in RUN -> same cycle pcWrEn=0,ifidWrEn=0,idexBubble=1; next cycle (no hazard) all enables 1.
//  memReadIDEX=1,r2IDEX=5,r2IFID=5,usesR2IFID=0 -> no stall; usesR2IFID=1 -> stall.
//  LOAD_USE_STALLS=2, hazard -> exactly 2 bubble cycles, ctrlState 0->1->0.
//  memReq=1, memAck after 4 cycles -> 4 freeze cycles, ctrlState=2, release on ack cycle; 16 cycles no ack -> memTimeout=1.
//  branchTaken=1 with loadUse=1 and memReq=0 -> ifidFlush=idexFlush=1, idexBubble=0; with memReq=1 -> freeze wins.
//  rst_n=0 during MEM_WAIT -> next cycle ctrlState=0, memTimeout=0, enables 1; PIPE_STATS_EN build counters read 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state encodings,
// NOP-select constants and the per-stage control bundle with its canned patterns.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } ctrl_state_t;

    localparam logic SEL_INSTR = 1'b0;
    localparam logic SEL_NOP   = 1'b1;

    // Field order matches the top-level output order so the bundle can be unpacked in one assign.
    typedef struct packed {
        logic pc_wr_en;
        logic ifid_wr_en;
        logic idex_bubble;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_wr_en;
        logic memwb_bubble;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_RUN = '{
        pc_wr_en: 1'b1, ifid_wr_en: 1'b1, idex_bubble: SEL_INSTR, ifid_flush: SEL_INSTR,
        idex_flush: SEL_INSTR, exmem_wr_en: 1'b1, memwb_bubble: SEL_INSTR
    };

    localparam stage_ctrl_t CTRL_BUBBLE = '{
        pc_wr_en: 1'b0, ifid_wr_en: 1'b0, idex_bubble: SEL_NOP, ifid_flush: SEL_INSTR,
        idex_flush: SEL_INSTR, exmem_wr_en: 1'b1, memwb_bubble: SEL_INSTR
    };

    localparam stage_ctrl_t CTRL_FLUSH = '{
        pc_wr_en: 1'b1, ifid_wr_en: 1'b1, idex_bubble: SEL_INSTR, ifid_flush: SEL_NOP,
        idex_flush: SEL_NOP, exmem_wr_en: 1'b1, memwb_bubble: SEL_INSTR
    };

    localparam stage_ctrl_t CTRL_FREEZE = '{
        pc_wr_en: 1'b0, ifid_wr_en: 1'b0, idex_bubble: SEL_INSTR, ifid_flush: SEL_INSTR,
        idex_flush: SEL_INSTR, exmem_wr_en: 1'b0, memwb_bubble: SEL_NOP
    };

endpackage

// File: rtl/pipeline_stall_ctrl_load_use_compare.sv
// Load-use hazard detector: IF/ID source registers against the ID/EX load destination.
// Register 0 is deliberately not exempt.
module load_use_compare #(
    parameter int REG_W = 4
) (
    input  logic             mem_read,
    input  logic [REG_W-1:0] load_rd,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             uses_src2,
    output logic             load_use
);

    assign load_use = mem_read & ((load_rd == src1) | (uses_src2 & (load_rd == src2)));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze > branch flush > load-use stall.
// Optional statistics counters are built when PIPE_STATS_EN is defined.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int REG_W           = 4,
    parameter int LOAD_USE_STALLS = 1,
    parameter int MEM_TIMEOUT     = 15,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             memReadIDEX,
    input  logic [REG_W-1:0] r2IDEX,
    input  logic [REG_W-1:0] r1IFID,
    input  logic [REG_W-1:0] r2IFID,
    input  logic             usesR2IFID,
    input  logic             branchTaken,
    input  logic             memReq,
    input  logic             memAck,
    output logic             pcWrEn,
    output logic             ifidWrEn,
    output logic             idexBubble,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             exmemWrEn,
    output logic             memwbBubble,
    output logic [1:0]       ctrlState,
    output logic             memTimeout
`ifdef PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0] loadStallCnt,
    output logic [CNT_W-1:0] memWaitCnt,
    output logic [CNT_W-1:0] flushCnt
`endif
);

    localparam int STALL_W = 2;
    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    ctrl_state_t          state, state_nxt, ret_state, ret_nxt;
    logic [STALL_W-1:0]   stall_cnt, stall_nxt;
    logic [WAIT_W-1:0]    wait_cnt, wait_nxt;
    logic                 timeout_nxt;
    logic                 load_use;
    logic                 mem_stall;
    stage_ctrl_t          ctrl;

    load_use_compare #(.REG_W(REG_W)) u_load_use (
        .mem_read  (memReadIDEX),
        .load_rd   (r2IDEX),
        .src1      (r1IFID),
        .src2      (r2IFID),
        .uses_src2 (usesR2IFID),
        .load_use  (load_use)
    );

    // A zero-wait access (req and ack together) never freezes.
    assign mem_stall = memReq & ~memAck;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        ctrl        = CTRL_RUN;
        state_nxt   = state;
        ret_nxt     = ret_state;
        stall_nxt   = stall_cnt;
        wait_nxt    = wait_cnt;
        timeout_nxt = memTimeout;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    ctrl      = CTRL_FREEZE;
                    ret_nxt   = RUN;
                    state_nxt = MEM_WAIT;
                end else if (branchTaken) begin
                    ctrl = CTRL_FLUSH;
                end else if (load_use) begin
                    ctrl = CTRL_BUBBLE;
                    if (LOAD_USE_STALLS > 1) begin
                        stall_nxt = STALL_W'(LOAD_USE_STALLS - 1);
                        state_nxt = LOAD_STALL;
                    end
                end
            end
            LOAD_STALL: begin
                if (mem_stall) begin
                    ctrl      = CTRL_FREEZE;
                    ret_nxt   = LOAD_STALL;
                    state_nxt = MEM_WAIT;
                end else begin
                    ctrl      = CTRL_BUBBLE;
                    stall_nxt = stall_cnt - 1'b1;
                    if (stall_cnt == STALL_W'(1)) state_nxt = RUN;
                end
            end
            MEM_WAIT: begin
                if (memAck) begin
                    // Resume exactly where the freeze interrupted; hazards are not re-evaluated.
                    ctrl      = (ret_state == LOAD_STALL) ? CTRL_BUBBLE : CTRL_RUN;
                    wait_nxt  = '0;
                    state_nxt = ret_state;
                end else begin
                    ctrl = CTRL_FREEZE;
                    if (wait_cnt != WAIT_MAX) wait_nxt = wait_cnt + 1'b1;
                    if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) timeout_nxt = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: reset is synchronous (sampled on the clock edge) and all state updates are non-blocking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            ret_state  <= RUN;
            stall_cnt  <= '0;
            wait_cnt   <= '0;
            memTimeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            ret_state  <= ret_nxt;
            stall_cnt  <= stall_nxt;
            wait_cnt   <= wait_nxt;
            memTimeout <= timeout_nxt;
        end
    end

    assign {pcWrEn, ifidWrEn, idexBubble, ifidFlush, idexFlush, exmemWrEn, memwbBubble} = ctrl;
    assign ctrlState = state;

`ifdef PIPE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loadStallCnt <= '0;
            memWaitCnt   <= '0;
            flushCnt     <= '0;
        end else begin
            if (ctrl.idex_bubble && loadStallCnt != '1) loadStallCnt <= loadStallCnt + 1'b1;
            if (ctrl.memwb_bubble && memWaitCnt != '1)  memWaitCnt   <= memWaitCnt + 1'b1;
            if (ctrl.ifid_flush && flushCnt != '1)      flushCnt     <= flushCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: one instance with 1 load-use bubble, one with 2,
// both compared every cycle against a cycle-counting reference model.
module tb_pipeline_stall_ctrl;

    localparam int REG_W       = 4;
    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 16;

    // Expected {pcWrEn, ifidWrEn, idexBubble, ifidFlush, idexFlush, exmemWrEn, memwbBubble}
    localparam logic [6:0] C_NORM  = 7'b1100010;
    localparam logic [6:0] C_BUB   = 7'b0010010;
    localparam logic [6:0] C_FLUSH = 7'b1101110;
    localparam logic [6:0] C_FRZ   = 7'b0000001;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             memReadIDEX = 1'b0;
    logic [REG_W-1:0] r2IDEX = '0, r1IFID = '0, r2IFID = '0;
    logic             usesR2IFID = 1'b0, branchTaken = 1'b0, memReq = 1'b0, memAck = 1'b0;

    logic [6:0] ctl0, ctl1;
    logic [1:0] cs0, cs1;
    logic       tmo0, tmo1;
    logic [9:0] obs0, obs1;
`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] ls0, mw0, fl0, ls1, mw1, fl1;
`endif

    assign obs0 = {ctl0, cs0, tmo0};
    assign obs1 = {ctl1, cs1, tmo1};

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.REG_W(REG_W), .LOAD_USE_STALLS(1), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .memReadIDEX(memReadIDEX), .r2IDEX(r2IDEX), .r1IFID(r1IFID),
        .r2IFID(r2IFID), .usesR2IFID(usesR2IFID), .branchTaken(branchTaken), .memReq(memReq),
        .memAck(memAck), .pcWrEn(ctl0[6]), .ifidWrEn(ctl0[5]), .idexBubble(ctl0[4]),
        .ifidFlush(ctl0[3]), .idexFlush(ctl0[2]), .exmemWrEn(ctl0[1]), .memwbBubble(ctl0[0]),
        .ctrlState(cs0), .memTimeout(tmo0)
`ifdef PIPE_STATS_EN
        , .loadStallCnt(ls0), .memWaitCnt(mw0), .flushCnt(fl0)
`endif
    );

    pipeline_stall_ctrl #(.REG_W(REG_W), .LOAD_USE_STALLS(2), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut_s2 (
        .clk(clk), .rst_n(rst_n), .memReadIDEX(memReadIDEX), .r2IDEX(r2IDEX), .r1IFID(r1IFID),
        .r2IFID(r2IFID), .usesR2IFID(usesR2IFID), .branchTaken(branchTaken), .memReq(memReq),
        .memAck(memAck), .pcWrEn(ctl1[6]), .ifidWrEn(ctl1[5]), .idexBubble(ctl1[4]),
        .ifidFlush(ctl1[3]), .idexFlush(ctl1[2]), .exmemWrEn(ctl1[1]), .memwbBubble(ctl1[0]),
        .ctrlState(cs1), .memTimeout(tmo1)
`ifdef PIPE_STATS_EN
        , .loadStallCnt(ls1), .memWaitCnt(mw1), .flushCnt(fl1)
`endif
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: bubbles still owed, whether a memory wait is open, bubbles owed when it ends.
    int         bl[2], saved[2], wc[2], n_bl[2], n_saved[2], n_wc[2];
    bit         waiting[2], tmo[2], n_waiting[2], n_tmo[2];
    logic [9:0] expv[2];
`ifdef PIPE_STATS_EN
    int st_ld = 0, st_mw = 0, st_fl = 0;
`endif

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            bl[i] = 0; saved[i] = 0; wc[i] = 0; waiting[i] = 1'b0; tmo[i] = 1'b0;
        end
    endfunction

    function automatic void predict();
        for (int i = 0; i < 2; i++) begin
            int         nbub;
            bit         lu, ms;
            logic [6:0] c;
            logic [1:0] s;
            nbub = (i == 0) ? 1 : 2;
            lu = memReadIDEX && ((r2IDEX == r1IFID) || (usesR2IFID && (r2IDEX == r2IFID)));
            ms = memReq && !memAck;
            s  = waiting[i] ? 2'd2 : (bl[i] > 0 ? 2'd1 : 2'd0);
            n_bl[i] = bl[i]; n_saved[i] = saved[i]; n_wc[i] = wc[i];
            n_waiting[i] = waiting[i]; n_tmo[i] = tmo[i];
            c = C_NORM;
            if (waiting[i]) begin
                if (memAck) begin
                    c = (saved[i] > 0) ? C_BUB : C_NORM;
                    n_waiting[i] = 1'b0; n_wc[i] = 0; n_bl[i] = saved[i];
                end else begin
                    c = C_FRZ;
                    n_wc[i] = wc[i] + 1;
                    if (n_wc[i] >= MEM_TIMEOUT) n_tmo[i] = 1'b1;
                end
            end else if (bl[i] > 0) begin
                if (ms) begin
                    c = C_FRZ; n_waiting[i] = 1'b1; n_saved[i] = bl[i];
                end else begin
                    c = C_BUB; n_bl[i] = bl[i] - 1;
                end
            end else if (ms) begin
                c = C_FRZ; n_waiting[i] = 1'b1; n_saved[i] = 0;
            end else if (branchTaken) begin
                c = C_FLUSH;
            end else if (lu) begin
                c = C_BUB; n_bl[i] = nbub - 1;
            end
            expv[i] = {c, s, tmo[i]};
        end
    endfunction

    task automatic advance();
`ifdef PIPE_STATS_EN
        if (expv[0][9:3] == C_BUB) st_ld++;
        if (expv[0][9:3] == C_FRZ) st_mw++;
        if (expv[0][9:3] == C_FLUSH) st_fl++;
        if (!rst_n) begin st_ld = 0; st_mw = 0; st_fl = 0; end
`endif
        if (!rst_n) model_reset();
        else begin
            bl = n_bl; saved = n_saved; wc = n_wc; waiting = n_waiting; tmo = n_tmo;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(bit mr, int rd, int s1, int s2, bit u2, bit br, bit rq, bit ak);
        memReadIDEX = mr; r2IDEX = REG_W'(rd); r1IFID = REG_W'(s1); r2IFID = REG_W'(s2);
        usesR2IFID = u2; branchTaken = br; memReq = rq; memAck = ak;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1, 3, 3, 0, 0, 1, 1, 0);
        @(negedge clk); predict(); advance();   // DUT state unknown before the first edge
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); predict();
        if (obs0 !== expv[0]) begin fails++; $display("FAIL reset_hold s1: got %b required %b", obs0, expv[0]); end
        checks++;
        advance();
        rst_n = 1'b1;
        @(negedge clk); predict();
        if (obs0 !== {C_NORM, 2'd0, 1'b0}) begin fails++; $display("FAIL reset_state s1: got %b required %b", obs0, {C_NORM, 2'd0, 1'b0}); end
        checks++;
        if (obs1 !== expv[1]) begin fails++; $display("FAIL reset_state s2: got %b required %b", obs1, expv[1]); end
        checks++;
        advance();
    endtask

    task automatic test_load_use();
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: set_in(1, 3, 3, 0, 0, 0, 0, 0);
                3: set_in(1, 5, 0, 5, 0, 0, 0, 0);
                4: set_in(1, 5, 0, 5, 1, 0, 0, 0);
                default: set_in(0, 3, 3, 0, 0, 0, 0, 0);
            endcase
            @(negedge clk); predict();
            if (k == 0 && ctl0 !== C_BUB) begin fails++; $display("FAIL lu_same_cycle: got %b required %b", ctl0, C_BUB); end
            if (k == 1 && ctl0 !== C_NORM) begin fails++; $display("FAIL lu_release: got %b required %b", ctl0, C_NORM); end
            if (k == 1 && cs1 !== 2'd1) begin fails++; $display("FAIL lu2_state: got %0d required 1", cs1); end
            if (k == 3 && ctl0 !== C_NORM) begin fails++; $display("FAIL r2_unused: got %b required %b", ctl0, C_NORM); end
            if (k == 4 && ctl0 !== C_BUB) begin fails++; $display("FAIL r2_used: got %b required %b", ctl0, C_BUB); end
            if (k <= 1 || k == 3 || k == 4) checks++;
            if (obs0 !== expv[0]) begin fails++; $display("FAIL load_use s1 k=%0d: got %b required %b", k, obs0, expv[0]); end
            if (obs1 !== expv[1]) begin fails++; $display("FAIL load_use s2 k=%0d: got %b required %b", k, obs1, expv[1]); end
            checks += 2;
            advance();
        end
    endtask

    task automatic test_mem_wait();
        // 4 frozen cycles then ack, idle, then 17 cycles without ack, ack, idle
        for (int k = 0; k < 25; k++) begin
            if (k < 4) set_in(0, 0, 1, 1, 0, 0, 1, 0);
            else if (k == 4 || k == 23) set_in(0, 0, 1, 1, 0, 0, 1, 1);
            else if (k == 5 || k == 24) set_in(0, 0, 1, 1, 0, 0, 0, 0);
            else set_in(0, 0, 1, 1, 0, 0, 1, 0);
            @(negedge clk); predict();
            if (k >= 1 && k <= 3 && cs0 !== 2'd2) begin fails++; $display("FAIL wait_state k=%0d: got %0d required 2", k, cs0); end
            if (k == 4 && ctl0 !== C_NORM) begin fails++; $display("FAIL wait_release: got %b required %b", ctl0, C_NORM); end
            if (k == 21 && tmo0 !== 1'b0) begin fails++; $display("FAIL timeout_early: got %b required 0", tmo0); end
            if (k == 22 && tmo0 !== 1'b1) begin fails++; $display("FAIL timeout_set: got %b required 1", tmo0); end
            if ((k >= 1 && k <= 4) || k == 21 || k == 22) checks++;
            if (obs0 !== expv[0]) begin fails++; $display("FAIL mem_wait s1 k=%0d: got %b required %b", k, obs0, expv[0]); end
            if (obs1 !== expv[1]) begin fails++; $display("FAIL mem_wait s2 k=%0d: got %b required %b", k, obs1, expv[1]); end
            checks += 2;
            advance();
        end
    endtask

    task automatic test_branch_priority();
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: set_in(1, 2, 2, 0, 0, 1, 0, 0);
                1: set_in(1, 2, 2, 0, 0, 1, 1, 0);
                2: set_in(1, 2, 2, 0, 0, 1, 1, 1);
                3: set_in(1, 2, 2, 0, 0, 0, 1, 1);
                default: set_in(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            @(negedge clk); predict();
            if (k == 0 && ctl0 !== C_FLUSH) begin fails++; $display("FAIL branch_flush: got %b required %b", ctl0, C_FLUSH); end
            if (k == 1 && ctl0 !== C_FRZ) begin fails++; $display("FAIL freeze_wins: got %b required %b", ctl0, C_FRZ); end
            if (k == 3 && ctl0 !== C_BUB) begin fails++; $display("FAIL zero_wait: got %b required %b", ctl0, C_BUB); end
            if (k == 0 || k == 1 || k == 3) checks++;
            if (obs0 !== expv[0]) begin fails++; $display("FAIL branch s1 k=%0d: got %b required %b", k, obs0, expv[0]); end
            if (obs1 !== expv[1]) begin fails++; $display("FAIL branch s2 k=%0d: got %b required %b", k, obs1, expv[1]); end
            checks += 2;
            advance();
        end
    endtask

    task automatic test_back_to_back();
        // Hazard, then a freeze arriving inside the 2-bubble sequence, then back-to-back hazards.
        for (int k = 0; k < 9; k++) begin
            case (k)
                0: set_in(1, 7, 7, 0, 0, 0, 0, 0);
                1, 2: set_in(0, 0, 1, 1, 0, 1, 1, 0);
                3: set_in(0, 0, 1, 1, 0, 1, 0, 1);
                4, 5, 6: set_in(1, 4, 1, 4, 1, 0, 0, 0);
                default: set_in(0, 0, 1, 1, 0, 0, 0, 0);
            endcase
            @(negedge clk); predict();
            if (obs0 !== expv[0]) begin fails++; $display("FAIL b2b s1 k=%0d: got %b required %b", k, obs0, expv[0]); end
            if (obs1 !== expv[1]) begin fails++; $display("FAIL b2b s2 k=%0d: got %b required %b", k, obs1, expv[1]); end
            checks += 2;
            advance();
        end
    endtask

    task automatic test_reset_mid_wait();
        for (int k = 0; k < 6; k++) begin
            rst_n = (k != 3);
            if (k < 4) set_in(0, 0, 1, 1, 0, 0, 1, 0);
            else set_in(0, 0, 1, 1, 0, 0, 0, 0);
            @(negedge clk); predict();
            if (k == 4 && obs0 !== {C_NORM, 2'd0, 1'b0}) begin fails++; $display("FAIL reset_mid_wait: got %b required %b", obs0, {C_NORM, 2'd0, 1'b0}); end
`ifdef PIPE_STATS_EN
            if (k == 4 && {ls0, mw0, fl0} !== '0) begin fails++; $display("FAIL stats_cleared: got %0d %0d %0d required 0 0 0", ls0, mw0, fl0); end
            if (k == 4) checks++;
`endif
            if (k == 4) checks++;
            if (obs0 !== expv[0]) begin fails++; $display("FAIL rst_wait s1 k=%0d: got %b required %b", k, obs0, expv[0]); end
            if (obs1 !== expv[1]) begin fails++; $display("FAIL rst_wait s2 k=%0d: got %b required %b", k, obs1, expv[1]); end
            checks += 2;
            advance();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            set_in($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            @(negedge clk); predict();
            if (obs0 !== expv[0]) begin fails++; $display("FAIL random s1 k=%0d: got %b required %b", k, obs0, expv[0]); end
            if (obs1 !== expv[1]) begin fails++; $display("FAIL random s2 k=%0d: got %b required %b", k, obs1, expv[1]); end
            checks += 2;
            advance();
        end
        rst_n = 1'b1;
`ifdef PIPE_STATS_EN
        if (ls0 !== CNT_W'(st_ld) || mw0 !== CNT_W'(st_mw) || fl0 !== CNT_W'(st_fl)) begin
            fails++;
            $display("FAIL stats_totals: got %0d %0d %0d required %0d %0d %0d", ls0, mw0, fl0, st_ld, st_mw, st_fl);
        end
        checks++;
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch_priority();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
